seg_capture: RTL

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 112 +++++++++++
 1 files changed

// File: rtl/seg_capture.sv
// seg_capture: debounces an active-low seven-segment bus, decodes each
// accepted pattern to BCD and shifts digits into an 8-digit buffer.
// A pattern is accepted once it has been stable for STABLE_CYCLES edges and
// again every HOLD_CYCLES edges after that while it stays unchanged, so a
// digit that stays on the display is captured repeatedly.
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 25000,
    parameter logic [31:0] MATCH         = 32'h2001_0812
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic        clr,
    output logic [3:0]  digit_out,
    output logic        digit_valid,
    output logic        err,
    output logic [31:0] digits,
    output logic [3:0]  num_digits,
    output logic        match
);

    localparam logic [15:0] STABLE_N = 16'(STABLE_CYCLES);
    localparam logic [15:0] REHIT_N  = 16'(STABLE_CYCLES + HOLD_CYCLES);
    localparam logic [6:0]  BLANK    = 7'b1111111;

    typedef enum logic [1:0] {
        CODE_DIGIT,
        CODE_BLANK,
        CODE_ILLEGAL
    } code_kind_e;

    logic [6:0]  seg_q;
    logic [15:0] rc;
    logic [15:0] run_len;
    logic        accept;
    code_kind_e  kind;
    logic [3:0]  dec_digit;
    logic        take_digit;
    logic        take_err;
    logic [31:0] next_digits;
    logic [3:0]  next_num;

    // Decode the pattern on the bus this edge into a digit, blank or illegal.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        kind      = CODE_DIGIT;
        dec_digit = 4'd0;
        case (seg_in)
            7'b1000000: dec_digit = 4'd0;
            7'b1111001: dec_digit = 4'd1;
            7'b0100100: dec_digit = 4'd2;
            7'b0110000: dec_digit = 4'd3;
            7'b0011001: dec_digit = 4'd4;
            7'b0010010: dec_digit = 4'd5;
            7'b0000010: dec_digit = 4'd6;
            7'b1011000: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0010000: dec_digit = 4'd9;
            BLANK:      kind      = CODE_BLANK;
            default:    kind      = CODE_ILLEGAL;
        endcase
    end

    // Run length including this edge, accept strobe, and the post-edge buffer.
    always_comb begin
        // rc never exceeds STABLE+HOLD-1, so rc+1 fits in 16 bits.
        run_len     = (seg_in == seg_q) ? rc + 16'd1 : 16'd1;
        accept      = (run_len == STABLE_N) || (run_len == REHIT_N);
        // clr wins over a simultaneous accept: no shift and no pulses.
        take_digit  = accept && !clr && (kind == CODE_DIGIT);
        take_err    = accept && !clr && (kind == CODE_ILLEGAL);
        next_digits = digits;
        next_num    = num_digits;
        if (clr) begin
            next_digits = 32'd0;
            next_num    = 4'd0;
        end else if (take_digit) begin
            next_digits = {digits[27:0], dec_digit};
            next_num    = (num_digits == 4'd8) ? 4'd8 : num_digits + 4'd1;
        end
    end

    // All architectural state; match is judged on the buffer being written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q       <= BLANK;
            rc          <= 16'd0;
            digit_out   <= 4'd0;
            digit_valid <= 1'b0;
            err         <= 1'b0;
            digits      <= 32'd0;
            num_digits  <= 4'd0;
            match       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            seg_q       <= seg_in;
            rc          <= (run_len == REHIT_N) ? STABLE_N : run_len;
            digit_valid <= take_digit;
            err         <= take_err;
            digits      <= next_digits;
            num_digits  <= next_num;
            match       <= (next_num == 4'd8) && (next_digits == MATCH);
            if (take_digit) begin
                digit_out <= dec_digit;
            end
        end
    end

endmodule
